// File: rtl/alu_pkg.sv
// +----------------------------------------------------------------------------+
// | alu_pkg: opcode and FSM state encodings shared by the multi-cycle ALU.     |
// | ALU_DIV_EN makes opcode 4'b1111 (DIVU) a legal multi-cycle operation.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

  localparam logic [3:0] OP_MULU = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_NOT  = 4'd3;
  localparam logic [3:0] OP_NEG  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SLLV = 4'd10;
  localparam logic [3:0] OP_LUI  = 4'd11;
  localparam logic [3:0] OP_SLT  = 4'd12;
  localparam logic [3:0] OP_SLTU = 4'd13;
  localparam logic [3:0] OP_SRA  = 4'd14;
  localparam logic [3:0] OP_DIVU = 4'd15;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic is_multicycle(input logic [3:0] op);
`ifdef ALU_DIV_EN
    return (op == OP_MULU) || (op == OP_DIVU);
`else
    return (op == OP_MULU);
`endif
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_seq_muldiv.sv
// +----------------------------------------------------------------------------+
// | alu_seq_muldiv: one-bit-per-cycle shift-add multiplier and, with           |
// | ALU_DIV_EN, restoring divider. hi/lo present the post-iteration value so   |
// | the caller can capture the final result on the edge where done is high.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_seq_muldiv #(
  parameter int  WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic             r_busy;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;
  logic [WIDTH:0]   w_madd;

  assign w_madd = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);

`ifdef ALU_DIV_EN
  logic             r_div;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;

  assign w_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_opnd};

  // A zero divisor never borrows, giving an all-ones quotient and remainder = dividend.
  always_comb begin
    w_hi_nxt = w_madd[WIDTH:1];
    w_lo_nxt = {w_madd[0], r_lo[WIDTH-1:1]};
    if (r_div) begin
      if (!w_trial[WIDTH]) begin
        w_hi_nxt = w_trial[WIDTH-1:0];
        w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
      end else begin
        w_hi_nxt = w_shift[WIDTH-1:0];
        w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
      end
    end
  end
`else
  logic w_unused_div;
  assign w_unused_div = is_div;

  always_comb begin
    w_hi_nxt = w_madd[WIDTH:1];
    w_lo_nxt = {w_madd[0], r_lo[WIDTH-1:1]};
  end
`endif

  assign done = r_busy && (r_cnt == SHW'(WIDTH - 1));
  assign hi   = w_hi_nxt;
  assign lo   = w_lo_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_opnd <= '0;
`ifdef ALU_DIV_EN
      r_div  <= 1'b0;
`endif
    end else if (start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_hi   <= '0;
`ifdef ALU_DIV_EN
      r_div  <= is_div;
      r_lo   <= is_div ? a : b;
      r_opnd <= is_div ? b : a;
`else
      r_lo   <= b;
      r_opnd <= a;
`endif
    end else if (r_busy) begin
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
      r_cnt <= r_cnt + SHW'(1);
      if (done) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_multicycle.sv
// +----------------------------------------------------------------------------+
// | alu_multicycle: registered EX-stage ALU with valid/ready handshakes;       |
// | MULU (and DIVU under ALU_DIV_EN) run iteratively in alu_seq_muldiv.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_multicycle
  import alu_pkg::*;
#(
  parameter int  WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [SHW-1:0]   shmt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dataC,
  output logic [WIDTH-1:0] dataHi,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             err
);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_data_c;
  logic [WIDTH-1:0] r_data_hi;
  logic             r_zero;
  logic             r_negative;
  logic             r_carry;
  logic             r_overflow;
  logic             r_err;
  logic             r_md_err;

  logic             w_accept;
  logic             w_multi;
  logic             w_is_div;
  logic             w_div_zero;
  logic             w_md_start;
  logic             w_md_done;
  logic [WIDTH-1:0] w_md_hi;
  logic [WIDTH-1:0] w_md_lo;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_ovf;
  logic             w_err;

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign dataC     = r_data_c;
  assign dataHi    = r_data_hi;
  assign zero      = r_zero;
  assign negative  = r_negative;
  assign carry     = r_carry;
  assign overflow  = r_overflow;
  assign err       = r_err;

  assign w_accept   = in_valid && in_ready;
  assign w_multi    = is_multicycle(op);
  assign w_md_start = w_accept && w_multi;
`ifdef ALU_DIV_EN
  assign w_is_div   = (op == OP_DIVU);
`else
  assign w_is_div   = 1'b0;
`endif
  assign w_div_zero = w_is_div && (dataB == '0);

  assign w_sum  = {1'b0, dataA} + {1'b0, dataB};
  assign w_diff = {1'b0, dataA} - {1'b0, dataB};

  // MULU/DIVU fall into the default arm here but never use this result.
  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    w_err   = 1'b0;
    case (op)
      OP_ADD: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (dataA[WIDTH-1] == dataB[WIDTH-1]) && (w_sum[WIDTH-1] != dataA[WIDTH-1]);
      end
      OP_SUB: begin
        w_res   = w_diff[WIDTH-1:0];
        w_carry = w_diff[WIDTH];
        w_ovf   = (dataA[WIDTH-1] != dataB[WIDTH-1]) && (w_diff[WIDTH-1] != dataA[WIDTH-1]);
      end
      OP_NOT:  w_res = ~dataA;
      OP_NEG:  w_res = '0 - dataA;
      OP_AND:  w_res = dataA & dataB;
      OP_OR:   w_res = dataA | dataB;
      OP_XOR:  w_res = dataA ^ dataB;
      OP_SLL:  w_res = dataB << shmt;
      OP_SRL:  w_res = dataB >> shmt;
      OP_SRA:  w_res = $unsigned($signed(dataB) >>> shmt);
      OP_SLLV: w_res = dataB << dataA[SHW-1:0];
      OP_LUI:  w_res = dataB << (WIDTH / 2);
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(dataA) < $signed(dataB))};
      OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (dataA < dataB)};
      default: w_err = 1'b1;
    endcase
  end

  alu_seq_muldiv #(
    .WIDTH (WIDTH)
  ) u_seq_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (w_md_start),
    .is_div (w_is_div),
    .a      (dataA),
    .b      (dataB),
    .done   (w_md_done),
    .hi     (w_md_hi),
    .lo     (w_md_lo)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_data_c   <= '0;
      r_data_hi  <= '0;
      r_zero     <= 1'b0;
      r_negative <= 1'b0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_err      <= 1'b0;
      r_md_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_multi) begin
              r_state  <= ST_BUSY;
              r_md_err <= w_div_zero;
            end else begin
              r_state    <= ST_DONE;
              r_data_c   <= w_res;
              r_data_hi  <= '0;
              r_zero     <= (w_res == '0);
              r_negative <= w_res[WIDTH-1];
              r_carry    <= w_carry;
              r_overflow <= w_ovf;
              r_err      <= w_err;
            end
          end
        end
        ST_BUSY: begin
          // Capture the final iteration's value on the same edge it is computed.
          if (w_md_done) begin
            r_state    <= ST_DONE;
            r_data_c   <= w_md_lo;
            r_data_hi  <= w_md_hi;
            r_zero     <= (w_md_lo == '0);
            r_negative <= w_md_lo[WIDTH-1];
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_err      <= r_md_err;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
